// File: rtl/spi_slave.sv
// SPI slave endpoint: LSB-first, SCLK idle low, active-low CS, all pins oversampled in clk.
// MISO changes on SCLK rising edges and MOSI is captured on SCLK falling edges.
module spi_slave #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] slaveDataToSend,
    output logic [DATA_WIDTH-1:0] slaveDataReceived,
    output logic                  rxValid,
    output logic                  busy,
    input  logic                  SCLK,
    input  logic                  CS,
    input  logic                  MOSI,
    output logic                  MISO
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Synchronizer chains; index SYNC_STAGES-1 is the settled copy.
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_dly;
    logic                   cs_dly;

    logic sclk_s;
    logic cs_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] tx_d;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] rx_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  miso_q;
    logic                  miso_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  valid_q;
    logic                  valid_d;

    // CS chain resets high so the slave comes out of reset deselected.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sclk_dly  <= 1'b0;
            cs_dly    <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
            sclk_dly  <= sclk_sync[SYNC_STAGES-1];
            cs_dly    <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_dly;
    assign sclk_fall = ~sclk_s & sclk_dly;
    assign cs_fall   = ~cs_s & cs_dly;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            miso_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            miso_q  <= miso_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        miso_d  = miso_q;
        data_d  = data_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                // Any SCLK edge coincident with the CS fall is dropped here.
                if (cs_fall) begin
                    tx_d    = slaveDataToSend;
                    rx_d    = '0;
                    cnt_d   = '0;
                    miso_d  = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    miso_d = tx_q[0];
                    tx_d   = {1'b0, tx_q[DATA_WIDTH-1:1]};
                end else if (sclk_fall) begin
                    rx_d  = {mosi_s, rx_q[DATA_WIDTH-1:1]};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(DATA_WIDTH)) begin
                        data_d  = rx_d;
                        valid_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (cs_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign slaveDataReceived = data_q;
    assign rxValid           = valid_q;
    assign busy              = (state_q == SHIFT);
    assign MISO              = cs_s ? 1'bz : miso_q;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave; MISO carries a pull-up so a released line reads 1.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] slaveDataToSend;
    logic [7:0] slaveDataReceived;
    logic       rxValid;
    logic       busy;
    logic       SCLK;
    logic       CS;
    logic       MOSI;
    tri1        miso;

    int nchk  = 0;
    int npass = 0;
    int vcnt  = 0;

    spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk               (clk),
        .reset             (reset),
        .slaveDataToSend   (slaveDataToSend),
        .slaveDataReceived (slaveDataReceived),
        .rxValid           (rxValid),
        .busy              (busy),
        .SCLK              (SCLK),
        .CS                (CS),
        .MOSI              (MOSI),
        .MISO              (miso)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rxValid === 1'b1) vcnt++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One frame with SCLK = clk/8; leaves CS low on return.
    task automatic frame(input logic [7:0] mosi_byte, input int nbits, input logic [7:0] send_after,
                         output logic [7:0] miso_byte, output logic busy_mid);
        CS = 1'b0;
        tick(4);
        busy_mid = busy;
        slaveDataToSend = send_after;
        miso_byte = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mosi_byte[i];
            SCLK = 1'b1;
            tick(4);
            miso_byte[i] = miso;
            SCLK = 1'b0;
            tick(4);
        end
    endtask

    logic [7:0] mb;
    logic       bm;

    initial begin
        reset = 1'b1; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0; slaveDataToSend = 8'h00;
        tick(3);
        check("rst_rx",    slaveDataReceived, 8'h00);
        check("rst_valid", {7'b0, rxValid},   8'h00);
        check("rst_busy",  {7'b0, busy},      8'h00);
        check("rst_hiz",   {7'b0, miso},      8'h01);
        reset = 1'b0;
        tick(2);

        // Basic exchange
        slaveDataToSend = 8'h02;
        frame(8'h01, 8, 8'h02, mb, bm);
        check("basic_busy_mid", {7'b0, bm},        8'h01);
        check("basic_miso",     mb,                8'h02);
        check("basic_rx",       slaveDataReceived, 8'h01);
        check("basic_vcnt",     8'(vcnt),          8'd1);
        check("basic_busy_done",{7'b0, busy},      8'h00);
        check("basic_hold",     {7'b0, miso},      8'h00);
        CS = 1'b1; tick(4);
        check("basic_hiz",      {7'b0, miso},      8'h01);

        // Back-to-back frames
        slaveDataToSend = 8'h00;
        frame(8'hFF, 8, 8'h00, mb, bm);
        check("b2b1_miso", mb,                8'h00);
        check("b2b1_rx",   slaveDataReceived, 8'hFF);
        CS = 1'b1; tick(4);
        check("b2b_gap_busy", {7'b0, busy},   8'h00);
        slaveDataToSend = 8'hF0;
        frame(8'h0F, 8, 8'hF0, mb, bm);
        check("b2b2_miso", mb,                8'hF0);
        check("b2b2_rx",   slaveDataReceived, 8'h0F);
        check("b2b_vcnt",  8'(vcnt),          8'd3);
        CS = 1'b1; tick(4);

        // Mid-frame abort after 4 bits
        slaveDataToSend = 8'h35;
        frame(8'hAA, 4, 8'h35, mb, bm);
        check("abort_miso", mb, 8'h05);
        CS = 1'b1; tick(4);
        check("abort_vcnt", 8'(vcnt),          8'd3);
        check("abort_rx",   slaveDataReceived, 8'h0F);
        check("abort_busy", {7'b0, busy},      8'h00);
        check("abort_hiz",  {7'b0, miso},      8'h01);
        slaveDataToSend = 8'h5A;
        frame(8'h31, 8, 8'h5A, mb, bm);
        check("post_abort_miso", mb,                8'h5A);
        check("post_abort_rx",   slaveDataReceived, 8'h31);
        check("post_abort_vcnt", 8'(vcnt),          8'd4);
        CS = 1'b1; tick(4);

        // Load timing: change slaveDataToSend after CS fell
        slaveDataToSend = 8'h1A;
        frame(8'h3C, 8, 8'hC6, mb, bm);
        check("load_miso", mb,                8'h1A);
        check("load_rx",   slaveDataReceived, 8'h3C);
        CS = 1'b1; tick(4);
        frame(8'h96, 8, 8'hC6, mb, bm);
        check("load_next_miso", mb,                8'hC6);
        check("load_next_rx",   slaveDataReceived, 8'h96);
        check("load_vcnt",      8'(vcnt),          8'd6);
        CS = 1'b1; tick(4);

        // Reset during a frame after 3 bits
        slaveDataToSend = 8'h03;
        frame(8'hFF, 3, 8'h03, mb, bm);
        check("rstf_miso",     mb,           8'h03);
        check("rstf_busy_mid", {7'b0, busy}, 8'h01);
        reset = 1'b1;
        tick(1);
        check("rstf_rx",    slaveDataReceived, 8'h00);
        check("rstf_valid", {7'b0, rxValid},   8'h00);
        check("rstf_busy",  {7'b0, busy},      8'h00);
        check("rstf_hiz",   {7'b0, miso},      8'h01);
        CS = 1'b1; tick(3);
        reset = 1'b0;
        tick(4);
        check("rstf_vcnt", 8'(vcnt), 8'd6);

        // Deselected SCLK activity
        for (int i = 0; i < 8; i++) begin
            MOSI = i[0];
            SCLK = 1'b1; tick(4);
            SCLK = 1'b0; tick(4);
        end
        check("desel_hiz",  {7'b0, miso},      8'h01);
        check("desel_vcnt", 8'(vcnt),          8'd6);
        check("desel_rx",   slaveDataReceived, 8'h00);
        check("desel_busy", {7'b0, busy},      8'h00);

        // Normal frame after all of the above
        slaveDataToSend = 8'h81;
        frame(8'h7E, 8, 8'h81, mb, bm);
        check("final_miso", mb,                8'h81);
        check("final_rx",   slaveDataReceived, 8'h7E);
        check("final_vcnt", 8'(vcnt),          8'd7);
        CS = 1'b1; tick(4);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
